// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for a 5-stage in-order core.
// Decodes the ID instruction into a control bundle that travels ID->EX->MEM->WB
// with a valid bit, resolves load-use stalls and taken-branch flushes.
// Optional mult/div interlock is enabled by defining PIPE_CTRL_MULTDIV_EN;
// without it mul/div decode as plain R-type and md_start is tied low.
module pipe_ctrl #(
  parameter int OPW  = 5,
  parameter int REGW = 5,
  parameter int AOPW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [AOPW-1:0] id_aluop,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic            ex_taken,
  input  logic            md_ready,
  output logic            stall_if,
  output logic            flush,
  output logic            md_start,
  output logic            ex_valid,
  output logic            ex_ALUinB,
  output logic            ex_is_branch,
  output logic            mem_valid,
  output logic            mem_DMwe,
  output logic            wb_valid,
  output logic            wb_Rwe,
  output logic            wb_Rwd,
  output logic [REGW-1:0] wb_rd
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_J     = OPW'(1);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(2);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
  localparam logic [OPW-1:0] OP_JR    = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(5);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(6);
  localparam logic [OPW-1:0] OP_SW    = OPW'(7);
  localparam logic [OPW-1:0] OP_LW    = OPW'(8);
  localparam logic [OPW-1:0] OP_SETX  = OPW'(21);
  localparam logic [OPW-1:0] OP_BEX   = OPW'(22);

  // ID decode results
  logic            dec_rwe, dec_rwd, dec_dmwe, dec_aluinb, dec_branch, dec_lw;
  logic [REGW-1:0] dec_rd;

  // EX (p0), MEM (p1), WB (p2) control bundles
  logic            vld_p0, rwe_p0, rwd_p0, dmwe_p0, aluinb_p0, branch_p0, lw_p0;
  logic [REGW-1:0] rd_p0;
  logic            vld_p1, rwe_p1, rwd_p1, dmwe_p1;
  logic [REGW-1:0] rd_p1;
  logic            vld_p2, rwe_p2, rwd_p2;
  logic [REGW-1:0] rd_p2;

  // hazard / interlock controls
  logic load_use, br_take, kill_id, md_hold;

  // Decode the ID opcode into stage enables; unknown opcodes stay all-zero
  always_comb begin
    dec_rwe    = 1'b0;
    dec_rwd    = 1'b0;
    dec_dmwe   = 1'b0;
    dec_aluinb = 1'b0;
    dec_branch = 1'b0;
    dec_lw     = 1'b0;
    dec_rd     = id_rd;
    case (id_opcode)
      OP_RTYPE: dec_rwe = 1'b1;
      OP_J:     dec_branch = 1'b1;
      OP_BNE:   dec_branch = 1'b1;
      OP_JAL: begin
        dec_rwe    = 1'b1;
        dec_branch = 1'b1;
        dec_rd     = REGW'(31);
      end
      OP_JR:    dec_branch = 1'b1;
      OP_ADDI: begin
        dec_rwe    = 1'b1;
        dec_aluinb = 1'b1;
      end
      OP_BLT:   dec_branch = 1'b1;
      OP_SW: begin
        dec_dmwe   = 1'b1;
        dec_aluinb = 1'b1;
      end
      OP_LW: begin
        dec_rwe    = 1'b1;
        dec_rwd    = 1'b1;
        dec_aluinb = 1'b1;
        dec_lw     = 1'b1;
      end
      OP_SETX: begin
        dec_rwe = 1'b1;
        dec_rd  = REGW'(30);
      end
      OP_BEX:   dec_branch = 1'b1;
      default: ;
    endcase
    // r0 is hardwired, never report a write to it
    if (dec_rd == '0) dec_rwe = 1'b0;
  end

  // A lw in EX feeding a source of the valid ID instruction needs one bubble
  assign load_use = vld_p0 && lw_p0 && (rd_p0 != '0) && id_valid &&
                    ((rd_p0 == id_rs) || (rd_p0 == id_rt));
  // ex_taken only counts for a valid branch sitting in EX
  assign br_take  = ex_taken && vld_p0 && branch_p0;
  // flush wins over the load-use stall; both are deferred while mult/div holds EX
  assign flush    = br_take && !md_hold;
  assign stall_if = md_hold || (load_use && !flush);
  assign kill_id  = flush || load_use;

`ifdef PIPE_CTRL_MULTDIV_EN
  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [AOPW-1:0] AOP_MUL = AOPW'(6);
  localparam logic [AOPW-1:0] AOP_DIV = AOPW'(7);

  md_state_t md_state, md_state_nxt;
  logic      dec_md, md_p0, md_start_c;

  assign dec_md = (id_opcode == OP_RTYPE) && ((id_aluop == AOP_MUL) || (id_aluop == AOP_DIV));

  // Mult/div state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) md_state <= IDLE;
    else        md_state <= md_state_nxt;
  end

  // Start the unit from a mul/div in EX, then hold EX until md_ready
  always_comb begin
    md_state_nxt = md_state;
    md_start_c   = 1'b0;
    md_hold      = 1'b0;
    case (md_state)
      IDLE: begin
        if (vld_p0 && md_p0) begin
          md_start_c   = 1'b1;
          md_hold      = 1'b1;
          md_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (md_ready) md_state_nxt = IDLE;
        else          md_hold      = 1'b1;
      end
      default: md_state_nxt = IDLE;
    endcase
  end

  assign md_start = md_start_c;

  // ---- ID -> EX boundary (mul/div tag) ----
  // Mul/div tag rides with the EX bundle and is held with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        md_p0 <= 1'b0;
    else if (!md_hold) md_p0 <= dec_md && !kill_id;
  end
`else
  logic unused_md;

  assign unused_md = ^{id_aluop, md_ready};
  assign md_hold   = 1'b0;
  assign md_start  = 1'b0;
`endif

  // ---- ID -> EX boundary ----
  // Load the EX bundle from ID, inserting a bubble on stall/flush, holding on mult/div
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0    <= 1'b0;
      rwe_p0    <= 1'b0;
      rwd_p0    <= 1'b0;
      dmwe_p0   <= 1'b0;
      aluinb_p0 <= 1'b0;
      branch_p0 <= 1'b0;
      lw_p0     <= 1'b0;
      rd_p0     <= '0;
    end else if (!md_hold) begin
      vld_p0    <= id_valid && !kill_id;
      rwe_p0    <= dec_rwe;
      rwd_p0    <= dec_rwd;
      dmwe_p0   <= dec_dmwe;
      aluinb_p0 <= dec_aluinb;
      branch_p0 <= dec_branch;
      lw_p0     <= dec_lw;
      rd_p0     <= dec_rd;
    end
  end

  // ---- EX -> MEM boundary ----
  // Advance EX into MEM, or feed MEM a bubble while EX is held
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      rwe_p1  <= 1'b0;
      rwd_p1  <= 1'b0;
      dmwe_p1 <= 1'b0;
      rd_p1   <= '0;
    end else begin
      vld_p1  <= vld_p0 && !md_hold;
      rwe_p1  <= rwe_p0;
      rwd_p1  <= rwd_p0;
      dmwe_p1 <= dmwe_p0;
      rd_p1   <= rd_p0;
    end
  end

  // ---- MEM -> WB boundary ----
  // Advance MEM into WB every cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      rwe_p2 <= 1'b0;
      rwd_p2 <= 1'b0;
      rd_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      rwe_p2 <= rwe_p1;
      rwd_p2 <= rwd_p1;
      rd_p2  <= rd_p1;
    end
  end

  assign ex_valid     = vld_p0;
  assign ex_ALUinB    = vld_p0 && aluinb_p0;
  assign ex_is_branch = vld_p0 && branch_p0;
  assign mem_valid    = vld_p1;
  assign mem_DMwe     = vld_p1 && dmwe_p1;
  assign wb_valid     = vld_p2;
  assign wb_rd        = vld_p2 ? rd_p2 : '0;
  assign wb_Rwe       = vld_p2 && rwe_p2 && (rd_p2 != '0);
  assign wb_Rwd       = vld_p2 && rwd_p2;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these parameters:
  - OPW, 5, opcode field width.
  - REGW, 5, register index width.
  - AOPW, 5, R-type ALU-op field width.
REQ-002 The block SHALL have these ports:
  - clock  in  1  single clock; all flops on rising edge.
  - reset  in  1  asynchronous, active-low; asserted when 0.
  - id_valid  in  1  ID stage holds a real instruction.
  - id_opcode  in  OPW  opcode of ID instruction.
  - id_aluop  in  AOPW  ALU-op field of ID instruction.
  - id_rs, id_rt, id_rd  in  REGW each  register fields of ID instruction.
  - ex_taken  in  1  EX resolved branch/jump as taken.
  - md_ready  in  1  mult/div unit result ready.
  - stall_if  out  1  hold PC and IF/ID register.
  - flush  out  1  kill the IF/ID contents.
  - md_start  out  1  one-cycle mult/div start pulse.
  - ex_valid, ex_ALUinB, ex_is_branch  out  1 each  EX-stage controls.
  - mem_valid, mem_DMwe  out  1 each  MEM-stage controls.
  - wb_valid, wb_Rwe, wb_Rwd  out  1 each  WB-stage controls.
  - wb_rd  out  REGW  WB destination register.

Function
REQ-003 ID decode SHALL use the team ISA:
  - R-type 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101.
  - blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
  - Any other opcode SHALL decode as a NOP (all enables 0).
REQ-004 Decoded enables:
  - Rwe = R-type|addi|lw|setx|jal.
  - DMwe = sw.
  - Rwd = lw.
  - ALUinB = addi|lw|sw.
  - is_branch = j|bne|jal|jr|blt|bex.
REQ-005 Destination override: jal SHALL write rd=31 and setx SHALL write rd=30; all others SHALL use id_rd.
REQ-006 Control bundles SHALL advance ID->EX->MEM->WB, one stage per cycle, each with a valid bit; a field output is qualified by its stage valid (forced 0 when valid=0).
REQ-007 wb_Rwe SHALL be 0 whenever wb_rd=0.
REQ-008 Load-use hazard: when ex_valid, EX is lw, EX rd!=0 and EX rd equals id_rs or id_rt of a valid ID instruction:
  - stall_if=1 combinationally.
  - A bubble (valid=0) enters EX at the next edge; ID is held for exactly one cycle.
REQ-009 Taken branch: ex_taken&ex_valid&ex_is_branch SHALL drive flush=1 in the same cycle; the ID instruction becomes a bubble in EX at the next edge.
REQ-010 When stall and flush are both raised, flush SHALL win: stall_if=0 and a bubble enters EX.
REQ-011 ex_taken SHALL be ignored when EX is not a valid branch.

Reset
REQ-012 With reset=0, asynchronously:
  - All valid bits and all registered controls go to 0, wb_rd goes to 0, the FSM goes to IDLE.
  - All outputs read 0.
REQ-013 Reset mid-stall or mid-mult/div SHALL abandon the operation; no md_start may follow release until a new mul/div reaches EX.

Configuration
REQ-014 Macro PIPE_CTRL_MULTDIV_EN enables the mult/div interlock.
REQ-015 With the macro defined, an FSM with states IDLE and BUSY SHALL operate:
  - Trigger: R-type in valid EX with id_aluop latched as 00110 (mul) or 00111 (div).
  - IDLE->BUSY: md_start=1 for that cycle only.
  - BUSY: stall_if=1, ID and EX are held, and bubbles enter MEM.
  - BUSY->IDLE: on the cycle md_ready=1, EX advances at that edge.
  - md_ready while IDLE SHALL be ignored.
  - A flush request while BUSY SHALL be deferred until the return to IDLE.
REQ-016 With the macro undefined:
  - mul/div SHALL behave as ordinary R-type.
  - md_start SHALL be tied 0 and md_ready ignored.
  - There SHALL be no FSM.

Verification
REQ-017 The bench SHALL cover these scenarios:
  - Reset: reset=0 mid-stream -> all outputs 0 asynchronously; after release, the first wb_valid appears 3 cycles after the first id_valid.
  - Load-use: lw r5 then add r6,r5,r2 -> stall_if=1 for exactly 1 cycle; the add reaches WB 4 cycles after entering ID, with wb_Rwe=1 and wb_rd=6.
  - Flush: bne in EX with ex_taken=1 while lw hazard is in ID -> flush=1, stall_if=0, bubble in EX, no MEM DMwe from the killed instruction.
  - Overrides: jal -> wb_rd=31, wb_Rwe=1; setx -> wb_rd=30; addi r0 -> wb_Rwe=0; opcode 11111 -> all enables 0.
  - Mult/div (macro defined): mul in EX -> md_start high 1 cycle; md_ready after 17 cycles -> stall_if high 17 cycles, then mul reaches WB next cycle.
  - Mult/div (macro undefined): same stream -> md_start stays 0 and no stall.
